// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Data wins by default; fetch is guaranteed a grant after STARVE_MAX consecutive data grants.
module unified_mem_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  input  logic          i_if_flush,
  output logic          o_if_valid,
  output logic [DW-1:0] o_if_rdata,
  output logic          o_if_stall,
  input  logic          i_d_req,
  input  logic          i_d_we,
  input  logic [2:0]    i_d_size,
  input  logic [AW-1:0] i_d_addr,
  input  logic [DW-1:0] i_d_wdata,
  output logic          o_d_valid,
  output logic [DW-1:0] o_d_rdata,
  output logic          o_d_stall,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [2:0]    o_mem_size,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic          i_mem_ack,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_busy
);

  localparam int unsigned SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam bit          STRICT_PRI = (STARVE_MAX == 0);
  localparam logic [2:0]  SIZE_WORD  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_D  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [SW-1:0] r_starve_cnt;
  logic          r_discard;
  logic          r_mem_req;
  logic          r_mem_we;
  logic [2:0]    r_mem_size;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;

  logic w_idle;
  logic w_starve_ok;
  logic w_grant_d;
  logic w_grant_if;
  logic w_ack_if;
  logic w_ack_d;

  // Grant decision is only taken in IDLE, which also spaces back-to-back grants
  assign w_idle      = (r_state == ST_IDLE);
  assign w_starve_ok = STRICT_PRI || (r_starve_cnt < STARVE_LIM);
  assign w_grant_d   = w_idle && i_d_req && (!i_if_req || w_starve_ok);
  assign w_grant_if  = w_idle && i_if_req && !w_grant_d;
  assign w_ack_if    = (r_state == ST_BUSY_IF) && i_mem_ack;
  assign w_ack_d     = (r_state == ST_BUSY_D) && i_mem_ack;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_d) begin
          w_state_nxt = ST_BUSY_D;
        end else if (w_grant_if) begin
          w_state_nxt = ST_BUSY_IF;
        end
      end
      ST_BUSY_IF: if (i_mem_ack) w_state_nxt = ST_IDLE;
      ST_BUSY_D:  if (i_mem_ack) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Pipeline-facing outputs; a flush on the ack cycle still suppresses the fetch
  always_comb begin
    o_if_valid = w_ack_if && !r_discard && !i_if_flush;
    o_d_valid  = w_ack_d;
    o_if_rdata = i_mem_rdata;
    o_d_rdata  = i_mem_rdata;
    o_if_stall = i_if_req && !o_if_valid;
    o_d_stall  = i_d_req && !o_d_valid;
    o_busy     = !w_idle;
  end

  // Memory request register, latched on the grant edge and held until ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_size  <= 3'b000;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_grant_d) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= i_d_we;
      r_mem_size  <= i_d_size;
      r_mem_addr  <= i_d_addr;
      r_mem_wdata <= i_d_wdata;
    end else if (w_grant_if) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_size  <= SIZE_WORD;
      r_mem_addr  <= i_if_addr;
    end else if (w_ack_if || w_ack_d) begin
      r_mem_req   <= 1'b0;
    end
  end

  // Fetch-starvation counter and flush-discard flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
      r_discard    <= 1'b0;
    end else begin
      if (w_grant_if || (w_idle && !i_if_req)) begin
        r_starve_cnt <= '0;
      end else if (w_grant_d && (r_starve_cnt != STARVE_LIM)) begin
        r_starve_cnt <= r_starve_cnt + SW'(1);
      end

      if (w_ack_if) begin
        r_discard <= 1'b0;
      end else if ((r_state == ST_BUSY_IF) && i_if_flush) begin
        r_discard <= 1'b1;
      end
    end
  end

  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_size  = r_mem_size;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

endmodule
